mmio_pdu_hub: RTL and testbench

Parametrised successor to the PDU-side memory-mapped I/O register block. It decodes CPU I/O-bus accesses onto LED, button, seven-segment, switch and counter resources. Switch-input and segment-output paths are buffered by FIFOs. It adds sticky button-edge flags, a loadable free-running counter and a maskable interrupt. It sits inside the PDU between the CPU I/O bus and the board peripherals.

---
 rtl/mmio_pdu_hub_if.sv | 15 +
 rtl/mmio_pdu_hub.sv | 188 ++++++++++++++++++
 tb/tb_mmio_pdu_hub.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pdu_hub_if.sv
// CPU I/O bus bundle between the CPU (master) and the PDU register hub (slave).
// Read data io_din is driven combinationally by the slave from io_addr.
interface mmio_pdu_hub_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_dout;
    logic              io_we;
    logic              io_rd;
    logic [DATA_W-1:0] io_din;

    modport master (output io_addr, io_dout, io_we, io_rd, input io_din);
    modport slave  (input io_addr, io_dout, io_we, io_rd, output io_din);
endinterface

// File: rtl/mmio_pdu_hub.sv
// PDU memory-mapped register hub: LED, sticky buttons, switch/segment FIFOs,
// loadable free-running counter and a maskable, registered interrupt.
module mmio_pdu_hub_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_ovf_clr,
    input  logic [DATA_W-1:0]        i_din,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic              w_pop;
    logic              w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = o_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
            if (i_push && !w_push)     r_ovf <= 1'b1;
            else if (i_ovf_clr)        r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
endmodule

module mmio_pdu_hub #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int LED_W     = 16,
    parameter int BTN_W     = 5,
    parameter int SW_DEPTH  = 4,
    parameter int SEG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    mmio_pdu_hub_if.slave        bus,
    input  logic                 sw_we,
    input  logic [DATA_W-1:0]    switches_din,
    input  logic                 seg_rd,
    output logic [DATA_W-1:0]    segment_dout,
    output logic                 seg_pending,
    input  logic [BTN_W-1:0]     buttons_din,
    output logic [LED_W-1:0]     led_dout,
    output logic                 irq
);
    localparam logic [ADDR_W-1:0] A_LED  = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_BTN  = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_SEGS = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_SEGD = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_SWS  = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_SWD  = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_CNT  = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] A_IRQ  = ADDR_W'(8'h1C);

    logic [DATA_W-1:0] r_led;
    logic [DATA_W-1:0] r_seg_out;
    logic [DATA_W-1:0] r_count;
    logic [2:0]        r_irq_en;
    logic              r_irq;
    logic [BTN_W-1:0]  r_btn_s1;
    logic [BTN_W-1:0]  r_btn_s2;
    logic [BTN_W-1:0]  r_btn_prev;
    logic [BTN_W-1:0]  r_btn_flags;

    logic [BTN_W-1:0]  w_rise;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_sw_head;
    logic [DATA_W-1:0] w_seg_head;
    logic [$clog2(SW_DEPTH):0]  w_sw_cnt;
    logic [$clog2(SEG_DEPTH):0] w_seg_cnt;
    logic w_sw_full, w_sw_empty, w_sw_ovf;
    logic w_seg_full, w_seg_empty, w_seg_ovf;
    logic w_rd_btn, w_rd_segs, w_rd_sws, w_rd_swd;
    logic w_wr_led, w_wr_segd, w_wr_cnt, w_wr_irq;

    assign w_rd_btn  = bus.io_rd && (bus.io_addr == A_BTN);
    assign w_rd_segs = bus.io_rd && (bus.io_addr == A_SEGS);
    assign w_rd_sws  = bus.io_rd && (bus.io_addr == A_SWS);
    assign w_rd_swd  = bus.io_rd && (bus.io_addr == A_SWD);
    assign w_wr_led  = bus.io_we && (bus.io_addr == A_LED);
    assign w_wr_segd = bus.io_we && (bus.io_addr == A_SEGD);
    assign w_wr_cnt  = bus.io_we && (bus.io_addr == A_CNT);
    assign w_wr_irq  = bus.io_we && (bus.io_addr == A_IRQ);

    mmio_pdu_hub_fifo #(.DATA_W(DATA_W), .DEPTH(SW_DEPTH)) u_sw_fifo (
        .clk(clk), .rstn(rstn), .i_push(sw_we), .i_pop(w_rd_swd), .i_ovf_clr(w_rd_sws),
        .i_din(switches_din), .o_head(w_sw_head), .o_count(w_sw_cnt),
        .o_full(w_sw_full), .o_empty(w_sw_empty), .o_ovf(w_sw_ovf)
    );

    mmio_pdu_hub_fifo #(.DATA_W(DATA_W), .DEPTH(SEG_DEPTH)) u_seg_fifo (
        .clk(clk), .rstn(rstn), .i_push(w_wr_segd), .i_pop(seg_rd), .i_ovf_clr(w_rd_segs),
        .i_din(bus.io_dout), .o_head(w_seg_head), .o_count(w_seg_cnt),
        .o_full(w_seg_full), .o_empty(w_seg_empty), .o_ovf(w_seg_ovf)
    );

    assign w_rise = r_btn_s2 & ~r_btn_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_led       <= '1;
            r_seg_out   <= DATA_W'(32'h1234_5678);
            r_count     <= '0;
            r_irq_en    <= '0;
            r_irq       <= 1'b0;
            r_btn_s1    <= '0;
            r_btn_s2    <= '0;
            r_btn_prev  <= '0;
            r_btn_flags <= '0;
        end else begin
            r_btn_s1    <= buttons_din;
            r_btn_s2    <= r_btn_s1;
            r_btn_prev  <= r_btn_s2;
            // set wins over clear-on-read per bit
            r_btn_flags <= (r_btn_flags & ~{BTN_W{w_rd_btn}}) | w_rise;
            if (w_wr_led) r_led <= bus.io_dout;
            if (w_wr_irq) r_irq_en <= bus.io_dout[2:0];
            r_count <= w_wr_cnt ? bus.io_dout : r_count + DATA_W'(1);
            if (seg_rd && !w_seg_empty) r_seg_out <= w_seg_head;
            r_irq <= (r_irq_en[0] && (r_btn_flags != '0)) ||
                     (r_irq_en[1] && !w_sw_empty) ||
                     (r_irq_en[2] && !w_seg_full);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.io_addr)
            A_LED:  w_rdata = r_led;
            A_BTN:  w_rdata[BTN_W-1:0] = r_btn_flags;
            A_SEGS: begin
                w_rdata[0]    = !w_seg_full;
                w_rdata[1]    = w_seg_empty;
                w_rdata[2]    = w_seg_ovf;
                w_rdata[15:8] = 8'(w_seg_cnt);
            end
            A_SWS: begin
                w_rdata[0]    = !w_sw_empty;
                w_rdata[1]    = w_sw_full;
                w_rdata[2]    = w_sw_ovf;
                w_rdata[15:8] = 8'(w_sw_cnt);
            end
            A_SWD:  w_rdata = w_sw_head;
            A_CNT:  w_rdata = r_count;
            A_IRQ:  w_rdata[2:0] = r_irq_en;
            default: w_rdata = '0;
        endcase
    end

    assign bus.io_din   = w_rdata;
    assign segment_dout = r_seg_out;
    assign seg_pending  = !w_seg_empty;
    assign led_dout     = r_led[LED_W-1:0];
    assign irq          = r_irq;
endmodule

// File: tb/tb_mmio_pdu_hub.sv
// Directed and randomized bench for mmio_pdu_hub, checked against a queue-based
// reference model of the register map, buttons and FIFOs.
module tb_mmio_pdu_hub;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  a;
    logic [31:0] d;
    logic        we, rd, swe, segrd;
    logic [31:0] swd;
    logic [4:0]  btn;
    logic [31:0] segment_dout;
    logic        seg_pending, irq;
    logic [15:0] led_dout;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] last_din;

    // reference model state
    logic [31:0] m_led, m_cnt, m_segout;
    logic [2:0]  m_en;
    logic [4:0]  m_btn, h1, h2, h3;
    logic        m_sw_ovf, m_seg_ovf, m_irq;
    logic [31:0] sw_q[$];
    logic [31:0] seg_q[$];

    mmio_pdu_hub_if #(.ADDR_W(8), .DATA_W(32)) bus();
    assign bus.io_addr = a;
    assign bus.io_dout = d;
    assign bus.io_we   = we;
    assign bus.io_rd   = rd;

    mmio_pdu_hub #(.ADDR_W(8), .DATA_W(32), .LED_W(16), .BTN_W(5),
                   .SW_DEPTH(4), .SEG_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .sw_we(swe), .switches_din(swd), .seg_rd(segrd),
        .segment_dout(segment_dout), .seg_pending(seg_pending),
        .buttons_din(btn), .led_dout(led_dout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led = '1; m_cnt = '0; m_segout = 32'h1234_5678; m_en = '0;
        m_btn = '0; h1 = '0; h2 = '0; h3 = '0;
        m_sw_ovf = 1'b0; m_seg_ovf = 1'b0; m_irq = 1'b0;
        sw_q.delete(); seg_q.delete();
    endtask

    function automatic logic [31:0] model_rd(input logic [7:0] ad);
        logic [31:0] r;
        r = '0;
        case (ad)
            8'h00: r = m_led;
            8'h04: r = {27'b0, m_btn};
            8'h08: r = {16'b0, 8'(seg_q.size()), 5'b0, m_seg_ovf,
                        seg_q.size() == 0, seg_q.size() < 4};
            8'h10: r = {16'b0, 8'(sw_q.size()), 5'b0, m_sw_ovf,
                        sw_q.size() == 4, sw_q.size() != 0};
            8'h14: r = (sw_q.size() != 0) ? sw_q[0] : 32'h0;
            8'h18: r = m_cnt;
            8'h1C: r = {29'b0, m_en};
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        logic [4:0] rise;
        logic       nirq, pop, full;
        nirq = (m_en[0] && m_btn != 0) || (m_en[1] && sw_q.size() != 0) ||
               (m_en[2] && seg_q.size() < 4);
        // h1..h3 are the button samples taken at the last three edges
        rise = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = btn;
        if (rd && a == 8'h04) m_btn = '0;
        m_btn = m_btn | rise;
        if (rd && a == 8'h08) m_seg_ovf = 1'b0;
        if (rd && a == 8'h10) m_sw_ovf = 1'b0;
        pop  = rd && a == 8'h14 && sw_q.size() != 0;
        full = sw_q.size() == 4;
        if (pop) void'(sw_q.pop_front());
        if (swe) begin
            if (!full || pop) sw_q.push_back(swd);
            else m_sw_ovf = 1'b1;
        end
        pop  = segrd && seg_q.size() != 0;
        full = seg_q.size() == 4;
        if (pop) m_segout = seg_q.pop_front();
        if (we && a == 8'h0C) begin
            if (!full || pop) seg_q.push_back(d);
            else m_seg_ovf = 1'b1;
        end
        m_cnt = (we && a == 8'h18) ? d : m_cnt + 1;
        if (we && a == 8'h00) m_led = d;
        if (we && a == 8'h1C) m_en = d[2:0];
        m_irq = nirq;
    endtask

    task automatic cyc();
        @(negedge clk);
        last_din = bus.io_din;
        chk("io_din", last_din, model_rd(a));
        @(posedge clk);
        model_edge();
        #1;
        chk("led_dout", 32'(led_dout), 32'(m_led[15:0]));
        chk("segment_dout", segment_dout, m_segout);
        chk("seg_pending", 32'(seg_pending), 32'(seg_q.size() != 0));
        chk("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [7:0] ad, input logic [31:0] dat);
        a = ad; d = dat; we = 1'b1; cyc(); we = 1'b0;
    endtask

    task automatic rdr(input logic [7:0] ad);
        a = ad; rd = 1'b1; cyc(); rd = 1'b0;
    endtask

    task automatic push_sw(input logic [31:0] dat);
        swd = dat; swe = 1'b1; cyc(); swe = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; a = '0; d = '0; we = 0; rd = 0; swe = 0; segrd = 0; swd = '0; btn = '0;
        model_reset();
        #16;
        chk("rst_led", 32'(led_dout), 32'h0000_FFFF);
        chk("rst_seg", segment_dout, 32'h1234_5678);
        chk("rst_pend", 32'(seg_pending), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        #1 rstn = 1'b1;

        // reset values and counter wrap
        rdr(8'h00); chk("led_rd", last_din, 32'hFFFF_FFFF);
        rdr(8'h18);
        wr(8'h18, 32'hFFFF_FFFE);
        rdr(8'h18); chk("cnt0", last_din, 32'hFFFF_FFFE);
        rdr(8'h18); chk("cnt1", last_din, 32'hFFFF_FFFF);
        rdr(8'h18); chk("cnt2", last_din, 32'h0000_0000);

        // switch FIFO overflow and drain
        for (int i = 1; i <= 5; i++) push_sw(32'(i));
        rdr(8'h10); chk("sw_stat_full", last_din, 32'h0000_0407);
        for (int i = 1; i <= 4; i++) begin
            rdr(8'h14); chk("sw_pop", last_din, 32'(i));
        end
        rdr(8'h10); chk("sw_stat_empty", last_din, 32'h0);
        rdr(8'h14); chk("sw_pop_empty", last_din, 32'h0);

        // segment FIFO full with simultaneous push and pop
        for (int i = 0; i < 4; i++) wr(8'h0C, 32'hA0 + 32'(i));
        a = 8'h0C; d = 32'hB0; we = 1'b1; segrd = 1'b1; cyc(); we = 1'b0; segrd = 1'b0;
        chk("seg_old_head", segment_dout, 32'hA0);
        rdr(8'h08); chk("seg_stat_full", last_din, 32'h0000_0400);
        segrd = 1'b1; idle(5); segrd = 1'b0;
        chk("seg_last", segment_dout, 32'hB0);
        rdr(8'h08); chk("seg_stat_empty", last_din, 32'h0000_0003);

        // buttons: sticky flag, clear-on-read, set beats clear
        btn = 5'b00100;
        idle(3);
        rdr(8'h04); chk("btn_set", last_din, 32'h4);
        rdr(8'h04); chk("btn_clr", last_din, 32'h0);
        idle(3);
        rdr(8'h04); chk("btn_hold", last_din, 32'h0);
        btn = '0; idle(4);
        btn = 5'b00100; idle(2);
        rdr(8'h04); chk("btn_rd_pre", last_din, 32'h0);
        rdr(8'h04); chk("btn_set_on_rd", last_din, 32'h4);
        btn = '0; idle(3);

        // switch-not-empty interrupt
        wr(8'h1C, 32'hFFFF_FFFA);
        rdr(8'h1C); chk("irq_en_rd", last_din, 32'h2);
        push_sw(32'hCAFE);
        chk("irq_lag", 32'(irq), 32'h0);
        idle(1);
        chk("irq_on", 32'(irq), 32'h1);
        rdr(8'h14); chk("irq_pop_data", last_din, 32'hCAFE);
        idle(1);
        chk("irq_off", 32'(irq), 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            int unsigned k;
            k = $urandom_range(8);
            a = (k == 8) ? 8'($urandom) : 8'(k * 4);
            d = $urandom;
            we = ($urandom_range(3) == 0);
            rd = ($urandom_range(2) == 0);
            swe = ($urandom_range(2) == 0);
            swd = $urandom;
            segrd = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) btn = 5'($urandom);
            cyc();
        end
        we = 0; rd = 0; swe = 0; segrd = 0; btn = '0;

        // asynchronous reset with FIFOs half full and counter running
        wr(8'h1C, 32'h7);
        while (sw_q.size() > 0) rdr(8'h14);
        segrd = 1'b1; idle(4); segrd = 1'b0;
        push_sw(32'h11); push_sw(32'h22);
        wr(8'h0C, 32'h33); wr(8'h0C, 32'h44);
        wr(8'h00, 32'h0000_5A5A);
        idle(2);
        #3 rstn = 1'b0;
        #1;
        chk("arst_led", 32'(led_dout), 32'h0000_FFFF);
        chk("arst_seg", segment_dout, 32'h1234_5678);
        chk("arst_pend", 32'(seg_pending), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        model_reset();
        @(posedge clk);
        #4 rstn = 1'b1;
        rdr(8'h10); chk("post_sw_stat", last_din, 32'h0);
        rdr(8'h08); chk("post_seg_stat", last_din, 32'h3);
        rdr(8'h14); chk("post_sw_data", last_din, 32'h0);
        rdr(8'h18);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
